// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller.
//   - One-hot FSM state encoding, built from per-phase bit positions.
//   - Default "no operation" opcode.
//   - next_phase(): picks the next enabled phase after the current one.
//     Phases that are not enabled are skipped in the same cycle.
package alu_issue_ctrl_pkg;

  // Bit positions of each phase inside the one-hot state vector.
  localparam int unsigned PH_IDLE = 0;
  localparam int unsigned PH_LOAD = 1;
  localparam int unsigned PH_EXEC = 2;
  localparam int unsigned PH_READ = 3;
  localparam int unsigned PH_RESP = 4;
  localparam int unsigned N_ST    = 5;

  localparam logic [4:0] NOP_OP_DEF = 5'h00;

  typedef enum logic [N_ST-1:0] {
    ST_IDLE = 5'(1 << PH_IDLE),
    ST_LOAD = 5'(1 << PH_LOAD),
    ST_EXEC = 5'(1 << PH_EXEC),
    ST_READ = 5'(1 << PH_READ),
    ST_RESP = 5'(1 << PH_RESP)
  } state_t;

  // Only meaningful from IDLE, LOAD or EXEC. Returns IDLE when nothing
  // further is enabled, which also covers a command with no phases at all.
  function automatic state_t next_phase(input state_t from,
                                        input logic   has_load,
                                        input logic   has_exec,
                                        input logic   has_rd);
    if (from == ST_IDLE && has_load)
      return ST_LOAD;
    if ((from == ST_IDLE || from == ST_LOAD) && has_exec)
      return ST_EXEC;
    if (has_rd)
      return ST_READ;
    return ST_IDLE;
  endfunction

endpackage

// File: rtl/alu_issue_skid.sv
// One-entry registered command buffer {op, data, arg, load, loadu, rd}.
// Input side is ready only while the entry is empty; the output side
// presents the stored command until the consumer takes it.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready/in_*    upstream command handshake and fields
//   out_valid/out_ready/out_* downstream command handshake and fields
module alu_issue_skid #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_arg,
  input  logic              in_load,
  input  logic              in_loadu,
  input  logic              in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_op,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_arg,
  output logic              out_load,
  output logic              out_loadu,
  output logic              out_rd
);

  logic full;

  assign in_ready  = ~full;
  assign out_valid = full;

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
    end else if (in_valid && !full) begin
      full <= 1'b1;
    end else if (full && out_ready) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && !full) begin
      out_op    <= in_op;
      out_data  <= in_data;
      out_arg   <= in_arg;
      out_load  <= in_load;
      out_loadu <= in_loadu;
      out_rd    <= in_rd;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts ALU commands over valid/ready, sequences
// the LOAD / EXEC / READ phases onto the ALU strobe interface, captures
// the accumulator/flag in READ and returns them over valid/ready.
// Build option: ALU_ISSUE_SKID_EN adds a one-entry command buffer so one
// command can be accepted while a transaction is in flight.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_op/data/arg/load/loadu/rd  command fields
//   alu_opcode/operand             registered ALU opcode and operand
//   alu_write/writeu/read          registered one-hot ALU strobes
//   alu_accout/alu_flag            ALU result inputs (valid during READ)
//   rsp_valid/rsp_ready            response handshake
//   rsp_data/rsp_flag              captured ALU result
//   busy                           FSM not in IDLE
module alu_issue_ctrl import alu_issue_ctrl_pkg::*; #(
  parameter int              DATA_W = 16,
  parameter int              OP_W   = 5,
  parameter logic [OP_W-1:0] NOP_OP = OP_W'(NOP_OP_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [DATA_W-1:0] cmd_arg,
  input  logic              cmd_load,
  input  logic              cmd_loadu,
  input  logic              cmd_rd,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [DATA_W-1:0] alu_operand,
  output logic              alu_write,
  output logic              alu_writeu,
  output logic              alu_read,
  input  logic [DATA_W-1:0] alu_accout,
  input  logic              alu_flag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_flag,
  output logic              busy
);

  state_t state, state_n;

  // Command as seen by the FSM (buffered or direct).
  logic              src_valid, src_ready;
  logic [OP_W-1:0]   src_op;
  logic [DATA_W-1:0] src_data, src_arg;
  logic              src_load, src_loadu, src_rd;

  // Command latched for the duration of the transaction.
  logic [OP_W-1:0]   cur_op;
  logic [DATA_W-1:0] cur_data, cur_arg;
  logic              cur_load, cur_loadu, cur_rd;

  // Command fields used to plan the next phase.
  logic              accept;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_data, sel_arg;
  logic              sel_load, sel_loadu, sel_rd, sel_wr, sel_ex;

  // Next-cycle ALU drive, registered below.
  logic [OP_W-1:0]   opcode_n;
  logic [DATA_W-1:0] operand_n;
  logic              write_n, writeu_n, read_n;

  assign src_ready = (state == ST_IDLE);

`ifdef ALU_ISSUE_SKID_EN
  logic skid_in_ready;

  alu_issue_skid #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (cmd_valid),
    .in_ready  (skid_in_ready),
    .in_op     (cmd_op),
    .in_data   (cmd_data),
    .in_arg    (cmd_arg),
    .in_load   (cmd_load),
    .in_loadu  (cmd_loadu),
    .in_rd     (cmd_rd),
    .out_valid (src_valid),
    .out_ready (src_ready),
    .out_op    (src_op),
    .out_data  (src_data),
    .out_arg   (src_arg),
    .out_load  (src_load),
    .out_loadu (src_loadu),
    .out_rd    (src_rd)
  );

  assign cmd_ready = skid_in_ready & ~rst;
`else
  assign src_valid = cmd_valid;
  assign src_op    = cmd_op;
  assign src_data  = cmd_data;
  assign src_arg   = cmd_arg;
  assign src_load  = cmd_load;
  assign src_loadu = cmd_loadu;
  assign src_rd    = cmd_rd;
  assign cmd_ready = src_ready & ~rst;
`endif

  assign accept = src_valid & src_ready;

  // On the accept cycle the latch is not yet loaded, so plan from the
  // incoming command; afterwards plan from the latched copy.
  always_comb begin
    sel_op    = accept ? src_op    : cur_op;
    sel_data  = accept ? src_data  : cur_data;
    sel_arg   = accept ? src_arg   : cur_arg;
    sel_load  = accept ? src_load  : cur_load;
    sel_loadu = accept ? src_loadu : cur_loadu;
    sel_rd    = accept ? src_rd    : cur_rd;
    sel_wr    = sel_load | sel_loadu;
    sel_ex    = (sel_op != NOP_OP);
  end

  always_comb begin
    state_n   = state;
    opcode_n  = NOP_OP;
    operand_n = '0;
    write_n   = 1'b0;
    writeu_n  = 1'b0;
    read_n    = 1'b0;

    case (state)
      ST_IDLE: if (accept) state_n = next_phase(ST_IDLE, sel_wr, sel_ex, sel_rd);
      ST_LOAD: state_n = next_phase(ST_LOAD, sel_wr, sel_ex, sel_rd);
      ST_EXEC: state_n = next_phase(ST_EXEC, sel_wr, sel_ex, sel_rd);
      ST_READ: state_n = ST_RESP;
      ST_RESP: if (rsp_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    // ALU outputs are registered, so they are decoded from the state
    // being entered; this keeps the strobes aligned with the phase.
    case (state_n)
      ST_LOAD: begin
        operand_n = sel_data;
        write_n   = sel_load;
        writeu_n  = ~sel_load & sel_loadu;
      end
      ST_EXEC: begin
        opcode_n  = sel_op;
        operand_n = sel_arg;
      end
      ST_READ: read_n = 1'b1;
      default: ;
    endcase
  end

  // Stage boundary: FSM state, ALU drive and captured response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      alu_opcode  <= NOP_OP;
      alu_operand <= '0;
      alu_write   <= 1'b0;
      alu_writeu  <= 1'b0;
      alu_read    <= 1'b0;
      rsp_data    <= '0;
      rsp_flag    <= 1'b0;
    end else begin
      state       <= state_n;
      alu_opcode  <= opcode_n;
      alu_operand <= operand_n;
      alu_write   <= write_n;
      alu_writeu  <= writeu_n;
      alu_read    <= read_n;
      if (state == ST_READ) begin
        rsp_data <= alu_accout;
        rsp_flag <= alu_flag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cur_op    <= src_op;
      cur_data  <= src_data;
      cur_arg   <= src_arg;
      cur_load  <= src_load;
      cur_loadu <= src_loadu;
      cur_rd    <= src_rd;
    end
  end

  // Masked during reset so a pending response is never offered.
  assign rsp_valid = (state == ST_RESP) & ~rst;
  assign busy      = (state != ST_IDLE) & ~rst;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [15:0] cmd_arg;
  logic        cmd_load;
  logic        cmd_loadu;
  logic        cmd_rd;
  logic [4:0]  alu_opcode;
  logic [15:0] alu_operand;
  logic        alu_write;
  logic        alu_writeu;
  logic        alu_read;
  logic [15:0] alu_accout;
  logic        alu_flag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_flag;
  logic        busy;

  alu_issue_ctrl #(.DATA_W(16), .OP_W(5), .NOP_OP(5'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_data    (cmd_data),
    .cmd_arg     (cmd_arg),
    .cmd_load    (cmd_load),
    .cmd_loadu   (cmd_loadu),
    .cmd_rd      (cmd_rd),
    .alu_opcode  (alu_opcode),
    .alu_operand (alu_operand),
    .alu_write   (alu_write),
    .alu_writeu  (alu_writeu),
    .alu_read    (alu_read),
    .alu_accout  (alu_accout),
    .alu_flag    (alu_flag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_flag    (rsp_flag),
    .busy        (busy)
  );

`ifdef ALU_ISSUE_SKID_EN
  localparam int SKID = 1;
`else
  localparam int SKID = 0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc_cyc;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct packed {
    logic [4:0]  op;
    logic [15:0] opd;
    logic        w, wu, rd;
  } ph_t;

  typedef struct packed {
    logic [4:0]  op;
    logic [15:0] d, a;
    logic        ld, ldu, rd;
  } cmd_t;

  ph_t   m_q[$];
  ph_t   m_cur;
  bit    m_cur_on, m_resp, m_sk_full, m_was_idle, m_take;
  cmd_t  m_sk, m_cmd;
  logic [15:0] m_rsp_data;
  logic        m_rsp_flag;

  // A command expands into its list of enabled phases; the ALU drive for
  // each cycle is the phase at the head of that list.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_q.delete();
      m_cur = '0; m_cur_on = 0; m_resp = 0; m_sk_full = 0;
      m_rsp_data = 16'h0; m_rsp_flag = 1'b0;
    end else begin
      m_was_idle = !m_cur_on && (m_q.size() == 0) && !m_resp;
      if (m_resp && rsp_ready) m_resp = 0;
      if (m_cur_on && m_cur.rd) begin
        m_rsp_data = alu_accout; m_rsp_flag = alu_flag; m_resp = 1;
      end
      m_cur = '0; m_cur_on = 0; m_take = 0;
      if (SKID != 0) begin
        if (m_was_idle && m_sk_full) begin
          m_take = 1; m_cmd = m_sk; m_sk_full = 0;
        end else if (!m_sk_full && cmd_valid) begin
          m_sk = '{cmd_op, cmd_data, cmd_arg, cmd_load, cmd_loadu, cmd_rd};
          m_sk_full = 1;
        end
      end else if (m_was_idle && cmd_valid) begin
        m_take = 1;
        m_cmd = '{cmd_op, cmd_data, cmd_arg, cmd_load, cmd_loadu, cmd_rd};
      end
      if (m_take) begin
        if (m_cmd.ld || m_cmd.ldu) m_q.push_back('{5'h00, m_cmd.d, m_cmd.ld, !m_cmd.ld, 1'b0});
        if (m_cmd.op != 5'h00)     m_q.push_back('{m_cmd.op, m_cmd.a, 1'b0, 1'b0, 1'b0});
        if (m_cmd.rd)              m_q.push_back('{5'h00, 16'h0, 1'b0, 1'b0, 1'b1});
      end
      if (m_q.size() > 0) begin
        m_cur = m_q.pop_front(); m_cur_on = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic e_idle, e_rdy;
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      e_idle = !m_cur_on && (m_q.size() == 0) && !m_resp;
      e_rdy  = (SKID != 0) ? (!rst && !m_sk_full) : (!rst && e_idle);
      chk("cmd_ready",   32'(cmd_ready),   32'(e_rdy));
      chk("busy",        32'(busy),        32'(!rst && !e_idle));
      chk("rsp_valid",   32'(rsp_valid),   32'(!rst && m_resp));
      chk("rsp_data",    32'(rsp_data),    32'(m_rsp_data));
      chk("rsp_flag",    32'(rsp_flag),    32'(m_rsp_flag));
      chk("alu_opcode",  32'(alu_opcode),  32'(m_cur.op));
      chk("alu_operand", 32'(alu_operand), 32'(m_cur.opd));
      chk("alu_write",   32'(alu_write),   32'(m_cur.w));
      chk("alu_writeu",  32'(alu_writeu),  32'(m_cur.wu));
      chk("alu_read",    32'(alu_read),    32'(m_cur.rd));
      chk("strobe_onehot", 32'(alu_write + alu_writeu + alu_read <= 2'd1), 32'd1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_cmd(input logic [4:0] op, input logic [15:0] d, input logic [15:0] a,
                          input logic ld, input logic ldu, input logic rd);
    bit ok = 0;
    cmd_op = op; cmd_data = d; cmd_arg = a;
    cmd_load = ld; cmd_loadu = ldu; cmd_rd = rd; cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: got cmd_ready=0 for 50 cycles expected 1");
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  // With the buffer the FSM picks the command up one cycle later.
  task automatic wait_issue();
    if (SKID != 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int b_cyc;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 5'h00; cmd_data = 16'h0; cmd_arg = 16'h0;
    cmd_load = 1'b0; cmd_loadu = 1'b0; cmd_rd = 1'b0; rsp_ready = 1'b0;
    alu_accout = 16'h0; alu_flag = 1'b0;
    step();
    chk_en = 1;
    @(negedge clk);
    chk("rst cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst busy",      32'(busy),      32'd0);
    chk("rst opcode",    32'(alu_opcode), 32'h00);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_data",  32'(rsp_data),  32'h0);
    step();
    rst = 1'b0;

    // 1: load-only command
    send_cmd(5'h00, 16'hFFFE, 16'h0, 1'b1, 1'b0, 1'b0);
    wait_issue();
    @(negedge clk);
    chk("t1 write",   32'(alu_write),   32'd1);
    chk("t1 operand", 32'(alu_operand), 32'hFFFE);
    @(negedge clk);
    chk("t1 write off", 32'(alu_write), 32'd0);
    chk("t1 rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t1 ready",     32'(cmd_ready), 32'd1);

    // 2: LOAD + EXEC + READ, response 3 cycles after issue
    step();
    alu_accout = 16'h1234; alu_flag = 1'b1;
    send_cmd(5'b00010, 16'hFFFE, 16'h0005, 1'b1, 1'b0, 1'b1);
    wait_issue();
    @(negedge clk);
    chk("t2 write",   32'(alu_write),   32'd1);
    chk("t2 ld opd",  32'(alu_operand), 32'hFFFE);
    @(negedge clk);
    chk("t2 exec op", 32'(alu_opcode),  32'h02);
    chk("t2 exec arg",32'(alu_operand), 32'h0005);
    @(negedge clk);
    chk("t2 read",    32'(alu_read),    32'd1);
    @(posedge clk); #1;
    alu_accout = 16'hDEAD; alu_flag = 1'b0;
    @(negedge clk);
    chk("t2 rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t2 rsp_data",  32'(rsp_data),  32'h1234);
    chk("t2 rsp_flag",  32'(rsp_flag),  32'd1);
    step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("t2 done valid", 32'(rsp_valid), 32'd0);
    chk("t2 done ready", 32'(cmd_ready), 32'd1);

    // 3: EXEC + READ with response back-pressure
    step();
    alu_accout = 16'h5A5A; alu_flag = 1'b0;
    send_cmd(5'b01110, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    wait_issue();
    @(negedge clk);
    chk("t3 exec op", 32'(alu_opcode), 32'h0E);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      alu_accout = 16'(16'h0F00 + i); alu_flag = 1'b1;
      @(negedge clk);
      chk("t3 hold valid", 32'(rsp_valid), 32'd1);
      chk("t3 hold data",  32'(rsp_data),  32'h5A5A);
      chk("t3 hold flag",  32'(rsp_flag),  32'd0);
      if (SKID == 0) chk("t3 hold ready", 32'(cmd_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("t3 idle busy", 32'(busy), 32'd0);

    // 4: reset during EXEC
    step();
    send_cmd(5'b00010, 16'h0001, 16'h0003, 1'b1, 1'b0, 1'b1);
    wait_issue();
    @(negedge clk);
    chk("t4 load", 32'(alu_write), 32'd1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("t4 exec op", 32'(alu_opcode), 32'h02);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t4 strobes", 32'({alu_write, alu_writeu, alu_read}), 32'd0);
    chk("t4 opcode",  32'(alu_opcode), 32'h00);
    chk("t4 valid",   32'(rsp_valid),  32'd0);
    chk("t4 busy",    32'(busy),       32'd0);
    chk("t4 data",    32'(rsp_data),   32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4 no rsp", 32'(rsp_valid), 32'd0);
    end

    // 5: LOADU then READ, response taken immediately
    step();
    rsp_ready = 1'b1;
    alu_accout = 16'hAB77; alu_flag = 1'b0;
    send_cmd(5'h00, 16'hAB00, 16'h0, 1'b0, 1'b1, 1'b1);
    wait_issue();
    @(negedge clk);
    chk("t5 writeu",  32'(alu_writeu),  32'd1);
    chk("t5 write",   32'(alu_write),   32'd0);
    chk("t5 operand", 32'(alu_operand), 32'hAB00);
    @(negedge clk);
    chk("t5 read",    32'(alu_read),    32'd1);
    chk("t5 write2",  32'(alu_write),   32'd0);
    @(negedge clk);
    chk("t5 rsp",     32'(rsp_data),    32'hAB77);
    chk("t5 valid",   32'(rsp_valid),   32'd1);
    @(negedge clk);
    chk("t5 taken",   32'(rsp_valid),   32'd0);

    // 6: back-to-back commands, and a command with no phases
    step();
    send_cmd(5'b00100, 16'h0, 16'h0007, 1'b0, 1'b0, 1'b1);
    b_cyc = acc_cyc;
    send_cmd(5'h00, 16'h0042, 16'h0, 1'b1, 1'b0, 1'b0);
    chk("t6 accept gap", 32'(acc_cyc - b_cyc), (SKID != 0) ? 32'd2 : 32'd4);
    for (int i = 0; i < 3 * SKID; i++) @(negedge clk);
    @(negedge clk);
    chk("t6 b write",   32'(alu_write),   32'd1);
    chk("t6 b operand", 32'(alu_operand), 32'h0042);
    rsp_ready = 1'b0;
    step();
    step();
    send_cmd(5'h00, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    wait_issue();
    @(negedge clk);
    chk("t6 drop busy",  32'(busy),      32'd0);
    chk("t6 drop write", 32'(alu_write), 32'd0);

    step();
    step();
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
